// File: rtl/tpm_pkg.sv
// Shared parameters, state encoding and weight helpers for the tree-parity machine blocks.
package tpm_pkg;

   localparam int unsigned K        = 2;
   localparam int unsigned N        = 3;
   localparam int unsigned WW       = 3;
   localparam int unsigned L        = 3;
   localparam int unsigned OUT_W    = 8;

   localparam int unsigned NW        = K * N;
   localparam int unsigned KEY_BITS  = NW * WW;
   localparam int unsigned WORDS     = (KEY_BITS + OUT_W - 1) / OUT_W;
   localparam int unsigned WORD_BITS = WORDS * OUT_W;
   localparam int unsigned ADDR_W    = (NW > 1) ? $clog2(NW) : 1;
   localparam int unsigned CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam int unsigned ERR_W        = 2;
   localparam int unsigned ERR_MISMATCH = 0;
   localparam int unsigned ERR_RANGE    = 1;

   typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;

   // True when a signed weight lies within -L..+L.
   function automatic logic in_range(input logic [WW-1:0] w);
      int sw;
      sw = int'($signed(w));
      return (sw >= -int'(L)) && (sw <= int'(L));
   endfunction

   // Offset-binary key field: u = w + L.
   function automatic logic [WW-1:0] encode(input logic [WW-1:0] w);
      return WW'(int'($signed(w)) + int'(L));
   endfunction

endpackage

// File: rtl/key_serializer.sv
// Parallel-load key register streamed out as OUT_W words, lowest word first, with valid/ready.
module key_serializer
   import tpm_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [KEY_BITS-1:0] key,
   output logic [OUT_W-1:0]    key_data,
   output logic                key_valid,
   input  logic                key_ready,
   output logic                key_last,
   output logic                last_hs_c
);

   logic [WORD_BITS-1:0] sh_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 valid_q;
   logic                 last_q;

   assign key_data  = sh_q[OUT_W-1:0];
   assign key_valid = valid_q;
   assign key_last  = last_q;
   assign last_hs_c = valid_q & key_ready & last_q;

   // Shift one word per handshake; the key is wiped after the final word leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load) begin
         sh_q    <= WORD_BITS'(key);
         cnt_q   <= '0;
         valid_q <= 1'b1;
         last_q  <= (WORDS == 1);
      end else if (valid_q && key_ready) begin
         if (last_q) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end else begin
            sh_q    <= sh_q >> OUT_W;
            cnt_q   <= cnt_q + CNT_W'(1);
            last_q  <= (cnt_q == CNT_W'(WORDS - 2));
         end
      end
   end

endmodule

// File: rtl/key_extract.sv
// Reads both partners' weights after sync, checks agreement and range, then streams the packed key.
module key_extract
   import tpm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              synced,
   output logic              wt_rd,
   output logic [ADDR_W-1:0] wt_addr,
   input  logic [WW-1:0]     wt_data_1,
   input  logic [WW-1:0]     wt_data_2,
   output logic [OUT_W-1:0]  key_data,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_last,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err
);

   state_t              state_q, state_d;
   logic                synced_q;
   logic                rd_q, rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                cap_q;
   logic [ADDR_W-1:0]   cap_idx_q;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                load_c;
   logic                fin_c;
   logic                start_c;
   logic                cap_last_c;
   logic                mismatch_c;
   logic                range_c;

   assign start_c    = synced & ~synced_q;
   assign cap_last_c = cap_q && (cap_idx_q == ADDR_W'(NW - 1));
   assign mismatch_c = (wt_data_1 != wt_data_2);
   assign range_c    = ~in_range(wt_data_1) | ~in_range(wt_data_2);

   assign wt_rd   = rd_q;
   assign wt_addr = addr_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         synced_q  <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         cap_q     <= 1'b0;
         cap_idx_q <= '0;
         err_q     <= '0;
         key_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         synced_q  <= synced;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         cap_q     <= rd_q;
         cap_idx_q <= addr_q;
         err_q     <= err_d;
         key_q     <= key_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rd_d    = 1'b0;
      addr_d  = addr_q;
      err_d   = err_q;
      key_d   = key_q;
      load_c  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_c) begin
               state_d = READ;
               rd_d    = 1'b1;
               addr_d  = '0;
            end
         end
         READ: begin
            if (rd_q && (addr_q != ADDR_W'(NW - 1))) begin
               rd_d   = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
            end
            // Captured pair arrives one cycle behind its strobe; flags are sticky.
            if (cap_q) begin
               err_d[ERR_MISMATCH] = err_q[ERR_MISMATCH] | mismatch_c;
               err_d[ERR_RANGE]    = err_q[ERR_RANGE] | range_c;
               key_d[int'(cap_idx_q) * int'(WW) +: WW] = encode(wt_data_1);
            end
            if (cap_last_c) begin
               if (err_d != '0) begin
                  state_d = DONE;
               end else begin
                  state_d = EMIT;
                  load_c  = 1'b1;
               end
            end
         end
         EMIT: begin
            if (fin_c) state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      // The secret must not outlive the extraction.
      if ((state_d == DONE) && (state_q != DONE)) key_d = '0;

      busy_d = (state_d == READ) || (state_d == EMIT);
      done_d = (state_d == DONE);
   end

   key_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c),
      .key       (key_d),
      .key_data  (key_data),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_last  (key_last),
      .last_hs_c (fin_c)
   );

endmodule

// File: tb/tb_key_extract.sv
// Scoreboard bench for key_extract: nominal, backpressure, error paths, mid-stream reset, re-trigger.
module tb_key_extract;
   import tpm_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              synced = 1'b0;
   logic              wt_rd;
   logic [ADDR_W-1:0] wt_addr;
   logic [WW-1:0]     wt_data_1 = '0;
   logic [WW-1:0]     wt_data_2 = '0;
   logic [OUT_W-1:0]  key_data;
   logic              key_valid;
   logic              key_ready = 1'b1;
   logic              key_last;
   logic              busy;
   logic              done;
   logic [ERR_W-1:0]  err;

   typedef struct {
      logic [OUT_W-1:0] d;
      logic             l;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [WW-1:0] w1 [NW];
   logic [WW-1:0] w2 [NW];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          hs_cnt = 0;
   bit          valid_seen = 1'b0;
   int          kv, kd;

   key_extract dut (
      .clk       (clk),
      .rst       (rst),
      .synced    (synced),
      .wt_rd     (wt_rd),
      .wt_addr   (wt_addr),
      .wt_data_1 (wt_data_1),
      .wt_data_2 (wt_data_2),
      .key_data  (key_data),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_last  (key_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Partner weight memories: data valid one cycle after the strobe.
   always @(posedge clk) begin
      if (wt_rd) begin
         wt_data_1 <= w1[wt_addr];
         wt_data_2 <= w2[wt_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: strobes must walk 0..NW-1; every handshake pops the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (wt_rd) begin
            check_eq("rd_addr", 32'(wt_addr), 32'(rd_cnt));
            rd_cnt++;
         end
         if (key_valid) valid_seen = 1'b1;
         if (key_valid && key_ready) begin
            check_eq("word_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check_eq("key_data", 32'(key_data), 32'(mon_e.d));
               check_eq("key_last", 32'(key_last), 32'(mon_e.l));
            end
            hs_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      exp_q.delete();
      rd_cnt     = 0;
      hs_cnt     = 0;
      valid_seen = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      synced    = 1'b0;
      key_ready = 1'b1;
      tick();
      tick();
      clear_counts();
      rst = 1'b0;
      tick();
   endtask

   task automatic set_nominal();
      for (int i = 0; i < int'(NW); i++) begin
         w1[i] = WW'(i - 3);
         w2[i] = WW'(i - 3);
      end
   endtask

   task automatic push_nominal();
      exp_q.push_back('{d: 8'h88, l: 1'b0});
      exp_q.push_back('{d: 8'hC6, l: 1'b0});
      exp_q.push_back('{d: 8'h02, l: 1'b1});
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_wt_rd"},     32'(wt_rd), 0);
      check_eq({tag, "_key_valid"}, 32'(key_valid), 0);
      check_eq({tag, "_key_data"},  32'(key_data), 0);
      check_eq({tag, "_key_last"},  32'(key_last), 0);
      check_eq({tag, "_busy"},      32'(busy), 0);
      check_eq({tag, "_done"},      32'(done), 0);
      check_eq({tag, "_err"},       32'(err), 0);
   endtask

   // Run from the synced edge until done; optional stall after the first handshake.
   task automatic run(input int stall, output int first_v, output int done_k);
      int stall_cnt;
      stall_cnt = 0;
      first_v   = 0;
      done_k    = 0;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (key_valid && first_v == 0) first_v = k;
         if (stall > 0 && hs_cnt == 1 && stall_cnt < stall) begin
            check_eq("bp_valid", 32'(key_valid), 1);
            check_eq("bp_data",  32'(key_data), 32'h0C6);
            check_eq("bp_last",  32'(key_last), 0);
            key_ready = 1'b0;
            stall_cnt++;
         end else begin
            key_ready = 1'b1;
         end
         if (done) begin
            done_k = k;
            break;
         end
      end
      check_eq("done_timeout", 32'(done), 1);
   endtask

   task automatic check_end(input string tag, input int exp_err, input int exp_hs);
      check_eq({tag, "_err"},   32'(err), 32'(exp_err));
      check_eq({tag, "_busy"},  32'(busy), 0);
      check_eq({tag, "_valid"}, 32'(key_valid), 0);
      check_eq({tag, "_reads"}, 32'(rd_cnt), NW);
      check_eq({tag, "_hs"},    32'(hs_cnt), 32'(exp_hs));
      check_eq({tag, "_left"},  32'(exp_q.size()), 0);
   endtask

   initial begin
      tick();
      check_idle_outputs("reset");

      // Nominal, ready held high.
      do_reset();
      set_nominal();
      push_nominal();
      synced = 1'b1;
      run(0, kv, kd);
      check_eq("nom_first_valid", 32'(kv), NW + 2);
      check_eq("nom_done_cycle",  32'(kd), NW + 2 + WORDS);
      check_end("nom", 0, 3);

      // DONE is terminal: a fresh synced edge must not restart reads.
      synced = 1'b0;
      tick();
      tick();
      synced = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("retrig_rd",    32'(wt_rd), 0);
         check_eq("retrig_done",  32'(done), 1);
         check_eq("retrig_valid", 32'(key_valid), 0);
      end
      check_eq("retrig_err", 32'(err), 0);

      // Backpressure: 5 stalled cycles after the first handshake.
      do_reset();
      set_nominal();
      push_nominal();
      synced = 1'b1;
      run(5, kv, kd);
      check_eq("bp_first_valid", 32'(kv), NW + 2);
      check_eq("bp_done_cycle",  32'(kd), NW + 2 + WORDS + 5);
      check_end("bp", 0, 3);

      // Partner mismatch at index 4.
      do_reset();
      set_nominal();
      w2[4] = 3'(2);
      synced = 1'b1;
      run(0, kv, kd);
      check_eq("mm_done_cycle", 32'(kd), NW + 2);
      check_eq("mm_valid_seen", 32'(valid_seen), 0);
      check_end("mm", 1, 0);

      // Out-of-range weight -4 on both partners at index 0.
      do_reset();
      set_nominal();
      w1[0] = 3'b100;
      w2[0] = 3'b100;
      synced = 1'b1;
      run(0, kv, kd);
      check_eq("rng_done_cycle", 32'(kd), NW + 2);
      check_eq("rng_valid_seen", 32'(valid_seen), 0);
      check_end("rng", 2, 0);

      // Reset after the first handshake, then restart with synced still high.
      do_reset();
      set_nominal();
      push_nominal();
      synced = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (hs_cnt == 1) break;
      end
      check_eq("rst_hs_reached", 32'(hs_cnt), 1);
      rst = 1'b1;
      #1;
      check_idle_outputs("rst_mid");
      tick();
      clear_counts();
      push_nominal();
      rst = 1'b0;
      run(0, kv, kd);
      check_eq("rst_first_valid", 32'(kv), NW + 2);
      check_eq("rst_done_cycle",  32'(kd), NW + 2 + WORDS);
      check_end("rst", 0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_extract.md
# key_extract

Harvests the shared secret after the two tree-parity partners have synchronised. Starts on the rising edge of the monitor's `synced` output. Reads every weight of both partners through a pipelined read port and checks that the two weight sets match and are in range. Packs the weights into a key and streams it out as a word stream with valid/ready backpressure to the downstream key consumer.

## Interface
- `K`, 2, hidden units per partner
- `N`, 3, inputs per hidden unit
- `WW`, 3, weight width, signed two's complement
- `L`, 3, weight bound; legal weights are −L..+L
- `OUT_W`, 8, output word width
- Derived: `NW = K*N`; `KEY_BITS = NW*WW`; `WORDS = ceil(KEY_BITS/OUT_W)`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `synced`  in  1  monitor sync flag (held high once set)
- `wt_rd`  out  1  weight read strobe
- `wt_addr`  out  clog2(NW)  weight index
- `wt_data_1`  in  WW  partner 1 weight; valid 1 cycle after strobe
- `wt_data_2`  in  WW  partner 2 weight; same timing as `wt_data_1`
- `key_data`  out  OUT_W  key word
- `key_valid`  out  1  `key_data` valid
- `key_ready`  in  1  consumer accepts
- `key_last`  out  1  final word, qualified by `key_valid`
- `busy`  out  1  high in READ/EMIT
- `done`  out  1  terminal flag
- `err`  out  2  [0] partner mismatch, [1] weight out of range

## Operation
- Reset value of every output is 0; `synced_q` = 0, state = IDLE, key register cleared.
- Edge detection: start when `synced & ~synced_q`. Because `synced_q` resets to 0, `synced` already high at reset release counts as an edge.
- IDLE: on edge → READ.
- READ: issue `wt_rd=1` with `wt_addr` = 0..NW−1 on consecutive cycles. Capture the pair one cycle after each strobe.
- Encoding: `u = w + L`, stored unsigned, WW bits, at key bits `[i*WW +: WW]` for index i.
- Mismatch: `wt_data_1 != wt_data_2` sets `err[0]`.
- Range error: w < −L or w > L sets `err[1]`.
- Error flags are sticky. The read pass always completes all NW indices.
- After the last capture:
  - if `err != 0` → DONE, with no key emitted;
  - otherwise → EMIT.
- EMIT: word j = key bits `[j*OUT_W +: OUT_W]`, lowest word first. Bits above KEY_BITS in the last word are 0. `key_last` is high on word WORDS−1. A word advances only on `key_valid & key_ready`.
- DONE: `done=1`, `busy=0`, `key_valid=0`. DONE is terminal until `rst`; further `synced` edges are ignored.
- The key register is zeroed on entry to DONE, so the secret does not persist.

## Timing
- Cycle c: edge sampled. Cycles c+1..c+NW: `wt_rd=1` with addr 0..NW−1. Cycles c+2..c+NW+1: captures.
- Cycle c+NW+2: first `key_valid` (EMIT), or `done` (error path).
- With `key_ready` held high, one word is emitted per cycle. `done` rises the cycle after the `key_last` handshake.
- Under backpressure, `key_data` and `key_last` stay stable while `key_valid & ~key_ready`. `key_valid` never drops before a handshake.
- `busy` is high from c+1 until the cycle before `done`.
- `rst` mid-READ or mid-EMIT: immediate return to the reset values. A stream that was in flight is abandoned with no `key_last`.

## Structure
- Package `tpm_pkg` holds:
  - K, N, WW, L, OUT_W;
  - derived NW, KEY_BITS, WORDS;
  - state enum {IDLE, READ, EMIT, DONE};
  - `err` bit positions.
- The package is shared with the monitor and the partner blocks.
- Sub-module `key_serializer`: parallel KEY_BITS load plus a valid/ready word stream with `key_last` and a word counter. Top level contains the FSM, read sequencer, checker and packer.

## Test plan
- Nominal: both partners = [−3,−2,−1,0,1,2], `key_ready`=1 → words 0x88, 0xC6, 0x02 on consecutive cycles, `key_last` on 0x02, then `done=1`, `err=0`.
- Backpressure: nominal, `key_ready` low 5 cycles after the first handshake → `key_data`=0xC6 held stable with `key_valid=1` for 5 cycles, then the stream completes normally.
- Mismatch: partner 2 index 4 = 2 vs 1 → full NW reads still issued, then `err=2'b01`, `done=1`, `key_valid` never asserted.
- Range: partner 1 and 2 index 0 = −4 (3'b100) → `err=2'b10`, `done=1`, no key emitted.
- Reset mid-stream: `rst` after the first handshake → all outputs 0 immediately. After release with `synced` high, the sequence restarts and emits 0x88 first.
- Re-trigger: in DONE, toggle `synced` low then high → no `wt_rd`, outputs unchanged.
